// File: rtl/t_frame_sequencer.sv
// Sequences one FFT frame per frame_ready_in into the T datapath and steers T's results into ping-pong banks.
// Optional DRAIN watchdog is enabled with `define T_SEQ_WATCHDOG_EN.
module t_frame_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int RD_LAT    = 2,
  parameter int WD_CYCLES = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_ready_in,
  output logic [$clog2(I)-1:0]  fft_rd_addr,
  input  logic [BIT_WIDTH-1:0]  fft_rd_data,
  output logic                  t_fft_valid,
  output logic [BIT_WIDTH-1:0]  t_fft_data,
  input  logic                  t_out_valid,
  input  logic [$clog2(I)-1:0]  t_out_addr,
  output logic                  wr_bank,
  output logic                  frame_done,
  output logic                  done_bank,
  output logic [1:0]            bank_full,
  input  logic [1:0]            bank_release,
  output logic [7:0]            drop_count,
  output logic                  busy,
  output logic                  error
);

  localparam int AW = $clog2(I);
  localparam logic [AW-1:0] LAST_ADDR = AW'(I - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state;
  logic [AW-1:0]     rd_cnt;
  logic              pending;
  logic [RD_LAT-1:0] vld_pipe;
  logic              bank_free;
  logic              start;
  logic              complete;
  logic              timeout;

  // A release arriving this cycle already frees the target bank, so a queued frame starts next cycle.
  always_comb begin
    bank_free = !bank_full[wr_bank] || bank_release[wr_bank];
    start     = (state == IDLE) && (frame_ready_in || pending) && bank_free;
    complete  = (state == DRAIN) && t_out_valid && (t_out_addr == LAST_ADDR);
  end

`ifdef T_SEQ_WATCHDOG_EN
  localparam int WDW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  logic [WDW-1:0] wd_cnt;
  logic           error_q;

  assign timeout = (state == DRAIN) && !complete && (wd_cnt == WDW'(WD_CYCLES - 1));
  assign error   = error_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt <= (state == DRAIN) ? wd_cnt + 1'b1 : '0;
      if (timeout) error_q <= 1'b1;
    end
  end
`else
  wire unused_wd = (WD_CYCLES == 0);
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      rd_cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (start) state <= READ;
        READ: begin
          if (rd_cnt == LAST_ADDR) begin
            state  <= GAP;
            rd_cnt <= '0;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        GAP:   state <= DRAIN;
        DRAIN: if (complete || timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One frame may wait; a start that consumes the queued frame re-queues a simultaneous new one.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending    <= 1'b0;
      drop_count <= '0;
    end else begin
      if (start) begin
        pending <= pending && frame_ready_in;
      end else if (frame_ready_in) begin
        if (!pending)
          pending <= 1'b1;
        else if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank_full  <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      done_bank  <= 1'b0;
    end else begin
      bank_full  <= (bank_full & ~bank_release) | (complete ? (2'b01 << wr_bank) : 2'b00);
      frame_done <= complete;
      if (complete) begin
        done_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  // The valid flag follows the BRAM read latency so it lines up with the returning data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == READ);
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign fft_rd_addr = rd_cnt;
  assign t_fft_valid = vld_pipe[RD_LAT-1];
  assign t_fft_data  = t_fft_valid ? fft_rd_data : '0;
  // GAP is part of the frame, so it reports busy as well.
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_t_frame_sequencer.sv
// Bench for t_frame_sequencer: BRAM and T models, a cycle vector table, corner sequences and a random run.
module tb_t_frame_sequencer;

  localparam int BW     = 32;
  localparam int NI     = 160;
  localparam int RD_LAT = 2;
  localparam int SUM_EXP = NI * (NI - 1) / 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_ready_in = 1'b0;
  logic [7:0]  fft_rd_addr;
  logic [BW-1:0] fft_rd_data;
  logic        t_fft_valid;
  logic [BW-1:0] t_fft_data;
  logic        t_out_valid;
  logic [7:0]  t_out_addr;
  logic        wr_bank, frame_done, done_bank, busy, error;
  logic [1:0]  bank_full;
  logic [1:0]  bank_release = 2'b00;
  logic [7:0]  drop_count;
  logic        t_suppress = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  t_frame_sequencer #(.BIT_WIDTH(BW), .I(NI), .RD_LAT(RD_LAT), .WD_CYCLES(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_ready_in(frame_ready_in),
    .fft_rd_addr(fft_rd_addr), .fft_rd_data(fft_rd_data),
    .t_fft_valid(t_fft_valid), .t_fft_data(t_fft_data),
    .t_out_valid(t_out_valid), .t_out_addr(t_out_addr),
    .wr_bank(wr_bank), .frame_done(frame_done), .done_bank(done_bank),
    .bank_full(bank_full), .bank_release(bank_release),
    .drop_count(drop_count), .busy(busy), .error(error)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: mem[k] = k, RD_LAT cycles of read latency.
  logic [BW-1:0] rdq [RD_LAT];
  always @(posedge clk_in) begin
    rdq[0] <= BW'(fft_rd_addr);
    for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign fft_rd_data = rdq[RD_LAT-1];

  // T model: running sum per burst (cleared by any low valid cycle), outputs three cycles after each input.
  int            t_cnt = 0;
  logic [BW-1:0] acc = '0;
  int            data_bad = 0;
  logic [2:0]    dv = '0;
  logic [7:0]    da [3];
  int            len_q [$];
  logic [BW-1:0] sum_q [$];

  always @(posedge clk_in) begin
    if (t_fft_valid) begin
      acc   <= (t_cnt == 0) ? t_fft_data : acc + t_fft_data;
      if (t_fft_data != BW'(t_cnt)) data_bad <= data_bad + 1;
      t_cnt <= t_cnt + 1;
    end else if (t_cnt != 0) begin
      len_q.push_back(t_cnt);
      sum_q.push_back(acc);
      t_cnt <= 0;
    end
    dv    <= {dv[1:0], t_fft_valid};
    da[0] <= t_cnt[7:0];
    da[1] <= da[0];
    da[2] <= da[1];
  end
  assign t_out_valid = dv[2] && !t_suppress;
  assign t_out_addr  = da[2];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    frame_ready_in = 1'b0;
    bank_release = 2'b00;
    t_suppress = 1'b0;
    repeat (3) step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic pulse();
    frame_ready_in = 1'b1;
    step();
    frame_ready_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    step();
    while (!frame_done && n < 1000) begin
      step();
      n++;
    end
    if (!frame_done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic clear_q();
    len_q.delete();
    sum_q.delete();
  endtask

  task automatic check_bursts(input string name, input int n_exp);
    chk({name, "_bursts"}, len_q.size(), n_exp);
    while (len_q.size() > 0) begin
      chk({name, "_len"}, len_q.pop_front(), NI);
      chk({name, "_sum"}, int'(sum_q.pop_front()), SUM_EXP);
    end
  endtask

  typedef struct {
    int cyc; bit fr; int addr; bit vld; int dat; bit bsy; bit done; int full; bit wrb; bit dbank;
  } vec_t;

  vec_t vec [$];
  logic [1:0] exp_full, rel_prev, set_mask;
  bit   exp_bank;
  int   n_pulse, n_done, cyc;
  bit   seen_done;

  initial begin
    // cycle 0 = cycle in which frame_ready_in is high
    vec.push_back('{0,   1, 0,   0, 0,   0, 0, 0, 0, 0});
    vec.push_back('{1,   0, 0,   0, 0,   1, 0, 0, 0, 0});
    vec.push_back('{2,   0, 1,   0, 0,   1, 0, 0, 0, 0});
    vec.push_back('{3,   0, 2,   1, 0,   1, 0, 0, 0, 0});
    vec.push_back('{4,   0, 3,   1, 1,   1, 0, 0, 0, 0});
    vec.push_back('{82,  0, 81,  1, 79,  1, 0, 0, 0, 0});
    vec.push_back('{160, 0, 159, 1, 157, 1, 0, 0, 0, 0});
    vec.push_back('{161, 0, 0,   1, 158, 1, 0, 0, 0, 0});
    vec.push_back('{162, 0, 0,   1, 159, 1, 0, 0, 0, 0});
    vec.push_back('{163, 0, 0,   0, 0,   1, 0, 0, 0, 0});
    vec.push_back('{165, 0, 0,   0, 0,   1, 0, 0, 0, 0});
    vec.push_back('{166, 0, 0,   0, 0,   0, 1, 1, 1, 0});
    vec.push_back('{167, 0, 0,   0, 0,   0, 0, 1, 1, 0});

    // single frame against the cycle table
    do_reset();
    chk("rst_drop", drop_count, 0);
    chk("rst_error", error, 0);
    clear_q();
    cyc = 0;
    for (int v = 0; v < vec.size(); v++) begin
      while (cyc < vec[v].cyc) begin
        step();
        cyc++;
        frame_ready_in = 1'b0;
      end
      chk($sformatf("c%0d_addr", cyc), fft_rd_addr, vec[v].addr);
      chk($sformatf("c%0d_vld", cyc), t_fft_valid, vec[v].vld);
      chk($sformatf("c%0d_dat", cyc), t_fft_data, vec[v].dat);
      chk($sformatf("c%0d_busy", cyc), busy, vec[v].bsy);
      chk($sformatf("c%0d_done", cyc), frame_done, vec[v].done);
      chk($sformatf("c%0d_full", cyc), bank_full, vec[v].full);
      chk($sformatf("c%0d_wrb", cyc), wr_bank, vec[v].wrb);
      if (vec[v].done) chk($sformatf("c%0d_dbank", cyc), done_bank, vec[v].dbank);
      frame_ready_in = vec[v].fr;
    end
    check_bursts("single", 1);

    // three frames, no releases: third waits until bank 0 is released
    do_reset();
    pulse();
    wait_done("f1");
    chk("f1_dbank", done_bank, 0);
    pulse();
    wait_done("f2");
    chk("f2_dbank", done_bank, 1);
    chk("f2_full", bank_full, 3);
    chk("f2_wrb", wr_bank, 0);
    pulse();
    repeat (20) step();
    chk("f3_wait_busy", busy, 0);
    bank_release = 2'b01;
    step();
    bank_release = 2'b00;
    chk("f3_start_busy", busy, 1);
    chk("f3_start_addr", fft_rd_addr, 0);
    chk("f3_start_full", bank_full, 2);
    wait_done("f3");
    chk("f3_dbank", done_bank, 0);
    chk("f3_full", bank_full, 3);

    // pending and drop accounting, then saturation
    do_reset();
    pulse();
    repeat (10) step();
    pulse();
    repeat (10) step();
    pulse();
    chk("drop_one", drop_count, 1);
    wait_done("drop_f1");
    step();
    chk("pending_starts", busy, 1);
    for (int k = 0; k < 300; k++) pulse();
    chk("drop_sat", drop_count, 255);

    // back-to-back frames: second burst must not inherit the first's sums
    do_reset();
    clear_q();
    pulse();
    wait_done("b2b_1");
    frame_ready_in = 1'b1;
    step();
    frame_ready_in = 1'b0;
    chk("b2b_restart", busy, 1);
    wait_done("b2b_2");
    chk("b2b_dbank", done_bank, 1);
    check_bursts("b2b", 2);

    // reset in the middle of a burst
    do_reset();
    pulse();
    for (int k = 0; k < 200 && fft_rd_addr != 8'd80; k++) step();
    chk("mid_addr_reached", fft_rd_addr, 80);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_vld", t_fft_valid, 0);
    chk("mid_rst_dat", t_fft_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", fft_rd_addr, 0);
    chk("mid_rst_full", bank_full, 0);
    chk("mid_rst_wrb", wr_bank, 0);
    step();
    rst_in = 1'b1;
    repeat (6) step();
    chk("mid_no_done", frame_done, 0);
    clear_q();
    pulse();
    wait_done("post_rst");
    chk("post_rst_dbank", done_bank, 0);
    chk("post_rst_full", bank_full, 1);
    check_bursts("post_rst", 1);

`ifdef T_SEQ_WATCHDOG_EN
    do_reset();
    t_suppress = 1'b1;
    seen_done = 1'b0;
    pulse();
    for (int k = 0; k < 224; k++) begin
      step();
      if (frame_done) seen_done = 1'b1;
    end
    chk("wd_before", error, 0);
    step();
    chk("wd_error", error, 1);
    chk("wd_idle", busy, 0);
    chk("wd_full", bank_full, 0);
    chk("wd_wrb", wr_bank, 0);
    chk("wd_no_done", seen_done, 0);
    repeat (10) step();
    chk("wd_sticky", error, 1);
    t_suppress = 1'b0;
`endif

    // random frames and releases against a bank-occupancy / frame-conservation model
    do_reset();
    clear_q();
    exp_full = 2'b00;
    exp_bank = 1'b0;
    rel_prev = 2'b00;
    n_pulse = 0;
    n_done = 0;
    for (int c = 0; c < 8000; c++) begin
      step();
      set_mask = 2'b00;
      if (frame_done) begin
        chk("rnd_dbank", done_bank, exp_bank);
        set_mask = 2'b01 << exp_bank;
        exp_bank = ~exp_bank;
        n_done++;
      end
      exp_full = (exp_full & ~rel_prev) | set_mask;
      chk("rnd_full", bank_full, exp_full);
      frame_ready_in = (c < 6000) && ($urandom_range(0, 149) == 0);
      if (frame_ready_in) n_pulse++;
      for (int b = 0; b < 2; b++)
        bank_release[b] = (c < 6000) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0);
      rel_prev = bank_release;
    end
    frame_ready_in = 1'b0;
    bank_release = 2'b00;
    step();
    chk("rnd_idle", busy, 0);
    chk("rnd_conserve", n_pulse, n_done + int'(drop_count));
    check_bursts("rnd", n_done);
    chk("data_order", data_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
